// File: rtl/tdc_interval_calc_pkg.sv
// Shared definitions for the TDC interval calculator: FSM state encodings and
// flag bit positions used by the top level and the testbench.
package tdc_interval_calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_CALC  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam int FLAGS_W        = 2;
   localparam int FLAG_TIMEOUT   = 1;
   localparam int FLAG_UNDERFLOW = 0;

endpackage : tdc_interval_calc_pkg

// File: rtl/tdc_coarse_counter.sv
// Saturating coarse cycle counter: clear has priority, then counts up while
// enabled and sticks at all ones.
module tdc_coarse_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             sat
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign sat   = &count_q;
   assign count = count_q;

   always_comb begin
      // NOTE: default first so every path assigns count_d; a missing branch would otherwise infer a latch.
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !sat) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : tdc_coarse_counter

// File: rtl/tdc_interval_calc.sv
// Measures the start-to-stop interval in delay-line bin units and presents it
// on a valid/ready handshake: coarse*BINS_PER_CLK + start_bin - stop_bin.
module tdc_interval_calc
   import tdc_interval_calc_pkg::*;
#(
   parameter  int BITS_DECO    = 8,
   parameter  int COARSE_BITS  = 16,
   parameter  int BINS_PER_CLK = 200,
   localparam int W            = COARSE_BITS + BITS_DECO + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start_valid,
   input  logic [BITS_DECO-1:0] i_start_bin,
   input  logic                 i_stop_valid,
   input  logic [BITS_DECO-1:0] i_stop_bin,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [W-1:0]         o_interval,
   output logic [FLAGS_W-1:0]   o_flags,
   output logic                 o_busy
);

   state_e               state_q,     state_d;
   logic [BITS_DECO-1:0] start_bin_q, start_bin_d;
   logic [BITS_DECO-1:0] stop_bin_q,  stop_bin_d;
   logic                 timeout_q,   timeout_d;
   logic [W-1:0]         interval_q,  interval_d;
   logic [FLAGS_W-1:0]   flags_q,     flags_d;

   logic                   cnt_clear;
   logic                   cnt_enable;
   logic [COARSE_BITS-1:0] coarse;
   logic                   coarse_sat;

   logic [W-1:0]       calc_raw;
   logic [W-1:0]       calc_interval;
   logic [FLAGS_W-1:0] calc_flags;

   tdc_coarse_counter #(
      .WIDTH (COARSE_BITS)
   ) u_coarse (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (coarse),
      .sat    (coarse_sat)
   );

   // The counter still advances in the stop cycle, so in CALC it holds the
   // number of cycles from start to stop (0 when both arrive together).
   assign cnt_enable = (state_q == ST_ARMED);

   // Modular W-bit arithmetic; the true range is far inside +/-2**(W-1), so the MSB is the sign.
   always_comb begin
      calc_raw      = (W'(coarse) * W'(BINS_PER_CLK)) + W'(start_bin_q) - W'(stop_bin_q);
      calc_interval = calc_raw;
      calc_flags    = '0;
      if (timeout_q) begin
         calc_interval              = '1;
         calc_flags[FLAG_TIMEOUT]   = 1'b1;
      end else if (calc_raw[W-1]) begin
         calc_interval              = '0;
         calc_flags[FLAG_UNDERFLOW] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      start_bin_d = start_bin_q;
      stop_bin_d  = stop_bin_q;
      timeout_d   = timeout_q;
      interval_d  = interval_q;
      flags_d     = flags_q;
      cnt_clear   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start_valid) begin
               start_bin_d = i_start_bin;
               timeout_d   = 1'b0;
               cnt_clear   = 1'b1;
               if (i_stop_valid) begin
                  stop_bin_d = i_stop_bin;
                  state_d    = ST_CALC;
               end else begin
                  state_d    = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (coarse_sat) begin
               timeout_d = 1'b1;
               state_d   = ST_CALC;
            end else if (i_stop_valid) begin
               stop_bin_d = i_stop_bin;
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            interval_d = calc_interval;
            flags_d    = calc_flags;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         start_bin_q <= '0;
         stop_bin_q  <= '0;
         timeout_q   <= 1'b0;
         interval_q  <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         start_bin_q <= start_bin_d;
         stop_bin_q  <= stop_bin_d;
         timeout_q   <= timeout_d;
         interval_q  <= interval_d;
         flags_q     <= flags_d;
      end
   end

   // Outputs decode registered state only, so o_valid never sees i_ready combinationally.
   assign o_valid    = (state_q == ST_HOLD);
   assign o_busy     = (state_q != ST_IDLE);
   assign o_interval = interval_q;
   assign o_flags    = flags_q;

endmodule : tdc_interval_calc

// File: tb/tb_tdc_interval_calc.sv
// Scoreboard bench for tdc_interval_calc: directed hits push hand-computed
// results; monitors pop and compare on every valid/ready transfer.
module tb_tdc_interval_calc;

   localparam int BD  = 8;
   localparam int CB  = 16;
   localparam int BPC = 200;
   localparam int W   = CB + BD + 1;
   localparam int TCB = 4;
   localparam int TW  = TCB + BD + 1;

   logic          clk = 1'b0;
   logic          rst;

   logic          i_start_valid, i_stop_valid, i_ready;
   logic [BD-1:0] i_start_bin, i_stop_bin;
   logic          o_valid, o_busy;
   logic [W-1:0]  o_interval;
   logic [1:0]    o_flags;

   logic          t_start_valid, t_stop_valid, t_ready;
   logic [BD-1:0] t_start_bin, t_stop_bin;
   logic          t_valid, t_busy;
   logic [TW-1:0] t_interval;
   logic [1:0]    t_flags;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W+1:0]  exp_q[$];
   logic [TW+1:0] t_exp_q[$];

   always #5 clk = ~clk;

   tdc_interval_calc #(.BITS_DECO(BD), .COARSE_BITS(CB), .BINS_PER_CLK(BPC)) dut (
      .clk(clk), .rst(rst),
      .i_start_valid(i_start_valid), .i_start_bin(i_start_bin),
      .i_stop_valid(i_stop_valid), .i_stop_bin(i_stop_bin),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_interval(o_interval), .o_flags(o_flags), .o_busy(o_busy)
   );

   tdc_interval_calc #(.BITS_DECO(BD), .COARSE_BITS(TCB), .BINS_PER_CLK(BPC)) dut_to (
      .clk(clk), .rst(rst),
      .i_start_valid(t_start_valid), .i_start_bin(t_start_bin),
      .i_stop_valid(t_stop_valid), .i_stop_bin(t_stop_bin),
      .o_valid(t_valid), .i_ready(t_ready),
      .o_interval(t_interval), .o_flags(t_flags), .o_busy(t_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!o_valid && n < budget) begin
         tick();
         n++;
      end
      check(name, 64'(o_valid), 64'd1);
   endtask

   // Monitors: every transfer on either DUT must match the head of its queue.
   always @(negedge clk) begin
      if (rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got interval %0d flags %b with no expected entry", o_interval, o_flags);
         end else begin
            logic [W+1:0] e;
            e = exp_q.pop_front();
            check("sb_interval", 64'(o_interval), 64'(e[W-1:0]));
            check("sb_flags", 64'(o_flags), 64'(e[W+1:W]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst && t_valid && t_ready) begin
         if (t_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL t_sb_unexpected: got interval %0h flags %b with no expected entry", t_interval, t_flags);
         end else begin
            logic [TW+1:0] e;
            e = t_exp_q.pop_front();
            check("t_sb_interval", 64'(t_interval), 64'(e[TW-1:0]));
            check("t_sb_flags", 64'(t_flags), 64'(e[TW+1:TW]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b0;
      i_start_valid = 1'b0; i_start_bin = '0; i_stop_valid = 1'b0; i_stop_bin = '0; i_ready = 1'b1;
      t_start_valid = 1'b0; t_start_bin = '0; t_stop_valid = 1'b0; t_stop_bin = '0; t_ready = 1'b1;

      #3;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_interval", 64'(o_interval), 64'd0);
      check("rst_flags", 64'(o_flags), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();

      // 1: start 50, stop 20 three cycles later -> 630, valid two cycles after stop
      i_start_valid = 1'b1; i_start_bin = 8'd50;
      tick();
      i_start_valid = 1'b0; i_start_bin = '0;
      @(negedge clk);
      check("t1_busy", 64'(o_busy), 64'd1);
      tick();
      tick();
      i_stop_valid = 1'b1; i_stop_bin = 8'd20;
      exp_q.push_back({2'b00, W'(630)});
      tick();
      i_stop_valid = 1'b0; i_stop_bin = '0;
      @(negedge clk);
      check("t1_valid_n1", 64'(o_valid), 64'd0);
      tick();
      @(negedge clk);
      check("t1_valid_n2", 64'(o_valid), 64'd1);
      tick();
      @(negedge clk);
      check("t1_idle_valid", 64'(o_valid), 64'd0);
      check("t1_idle_busy", 64'(o_busy), 64'd0);

      // 2: same-cycle start 120 / stop 40 -> 80
      tick();
      i_start_valid = 1'b1; i_start_bin = 8'd120; i_stop_valid = 1'b1; i_stop_bin = 8'd40;
      exp_q.push_back({2'b00, W'(80)});
      tick();
      i_start_valid = 1'b0; i_stop_valid = 1'b0;
      wait_valid("t2_wait", 5);
      tick();

      // 3: same-cycle start 10 / stop 30 -> underflow
      tick();
      i_start_valid = 1'b1; i_start_bin = 8'd10; i_stop_valid = 1'b1; i_stop_bin = 8'd30;
      exp_q.push_back({2'b01, W'(0)});
      tick();
      i_start_valid = 1'b0; i_stop_valid = 1'b0;
      wait_valid("t3_wait", 5);
      tick();

      // 4: timeout on the 4-bit instance, valid 18 cycles after start
      tick();
      t_start_valid = 1'b1; t_start_bin = 8'd3;
      t_exp_q.push_back({2'b10, {TW{1'b1}}});
      tick();
      t_start_valid = 1'b0;
      n = 0;
      while (!t_valid && n < 40) begin
         tick();
         n++;
      end
      check("t4_latency", 64'(n), 64'd17);
      check("t4_valid", 64'(t_valid), 64'd1);
      tick();
      @(negedge clk);
      check("t4_idle_busy", 64'(t_busy), 64'd0);

      // 5: HOLD with ready low for 10 cycles while extra hits arrive
      tick();
      i_ready = 1'b0;
      i_start_valid = 1'b1; i_start_bin = 8'd7;
      tick();
      i_start_valid = 1'b0;
      i_stop_valid = 1'b1; i_stop_bin = 8'd7;
      exp_q.push_back({2'b00, W'(200)});
      tick();
      i_stop_valid = 1'b0;
      wait_valid("t5_wait", 5);
      for (int i = 0; i < 10; i++) begin
         i_start_valid = 1'b1; i_start_bin = 8'd99; i_stop_valid = 1'b1; i_stop_bin = 8'd1;
         @(negedge clk);
         check("t5_hold_valid", 64'(o_valid), 64'd1);
         check("t5_hold_busy", 64'(o_busy), 64'd1);
         check("t5_hold_interval", 64'(o_interval), 64'd200);
         check("t5_hold_flags", 64'(o_flags), 64'd0);
         tick();
      end
      i_start_valid = 1'b0; i_stop_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      @(negedge clk);
      check("t5_release_valid", 64'(o_valid), 64'd0);
      check("t5_release_busy", 64'(o_busy), 64'd0);
      tick();
      tick();
      check("t5_dropped_busy", 64'(o_busy), 64'd0);

      // 6: reset while ARMED discards the measurement; then start 5 / stop 5 -> 200
      i_start_valid = 1'b1; i_start_bin = 8'd9;
      tick();
      i_start_valid = 1'b0;
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("t6_rst_valid", 64'(o_valid), 64'd0);
      check("t6_rst_interval", 64'(o_interval), 64'd0);
      check("t6_rst_flags", 64'(o_flags), 64'd0);
      check("t6_rst_busy", 64'(o_busy), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      i_start_valid = 1'b1; i_start_bin = 8'd5;
      tick();
      i_start_valid = 1'b0;
      i_stop_valid = 1'b1; i_stop_bin = 8'd5;
      exp_q.push_back({2'b00, W'(200)});
      tick();
      i_stop_valid = 1'b0;
      wait_valid("t6_wait", 5);
      tick();
      tick();

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      check("t_sb_drained", 64'(t_exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_tdc_interval_calc
